// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one shift per clock).
// Optional invalid-digit checking is built when BCD_TO_BINARY_CHECK_EN is defined.
//
// state | meaning
// IDLE  | waiting for i_Start; operand loaded on the accepting edge
// SHIFT | one right shift plus per-nibble correction each cycle
// DONE  | result transferred to o_Binary, o_Done pulsed on the exit edge
module bcd_to_binary #(
  parameter int DIGITS    = 2,
  parameter int BIN_WIDTH = 7
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic [4*DIGITS-1:0]   i_BCD,
  output logic [BIN_WIDTH-1:0]  o_Binary,
  output logic                  o_Done,
  output logic                  o_Busy,
  output logic                  o_Error
);

  localparam int BCD_W   = 4 * DIGITS;
  localparam int COUNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [COUNT_W-1:0] LAST_SHIFT = COUNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_next;
  logic [BCD_W-1:0]     r_bcd, bcd_shift, bcd_next;
  logic [BIN_WIDTH-1:0] r_bin, bin_next;
  logic [COUNT_W-1:0]   r_count;
  logic [3:0]           nib;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_Busy     = 1'b0;
    case (state)
      IDLE:  if (i_Start) state_next = SHIFT;
      SHIFT: begin
        o_Busy = 1'b1;
        if (r_count == LAST_SHIFT) state_next = DONE;
      end
      DONE: begin
        o_Busy     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift the combined {bcd, bin} register right, then pull each nibble >= 8 back by 3.
  always_comb begin
    nib       = '0;
    bcd_next  = '0;
    bcd_shift = r_bcd >> 1;
    bin_next  = {r_bcd[0], r_bin[BIN_WIDTH-1:1]};
    for (int d = 0; d < DIGITS; d++) begin
      nib = bcd_shift[4*d +: 4];
      if (nib >= 4'd8) nib = nib - 4'd3;
      bcd_next[4*d +: 4] = nib;
    end
  end

`ifdef BCD_TO_BINARY_CHECK_EN
  logic r_invalid, bcd_bad;

  always_comb begin
    bcd_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      if (i_BCD[4*d +: 4] > 4'd9) bcd_bad = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_invalid <= 1'b0;
      o_Error   <= 1'b0;
    end else if (state == IDLE && i_Start) begin
      r_invalid <= bcd_bad;
      o_Error   <= 1'b0;
    end else if (state == DONE) begin
      o_Error   <= r_invalid;
    end
  end
`else
  assign o_Error = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_bcd    <= '0;
      r_bin    <= '0;
      r_count  <= '0;
      o_Binary <= '0;
      o_Done   <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: if (i_Start) begin
          r_bcd   <= i_BCD;
          r_bin   <= '0;
          r_count <= '0;
        end
        SHIFT: begin
          r_bcd   <= bcd_next;
          r_bin   <= bin_next;
          r_count <= r_count + COUNT_W'(1);
        end
        DONE: begin
`ifdef BCD_TO_BINARY_CHECK_EN
          o_Binary <= r_invalid ? '0 : r_bin;
`else
          o_Binary <= r_bin;
`endif
          o_Done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: default 2-digit instance plus a 3-digit/10-bit instance.
// Expected results are queued at stimulus time and popped when o_Done is observed.
module tb_bcd_to_binary;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bcd;
  logic [6:0] bin;
  logic       done, busy, err;

  logic        w_start;
  logic [11:0] w_bcd;
  logic [9:0]  w_bin;
  logic        w_done, w_busy, w_err;

  int vectors = 0;
  int miscompares = 0;
  int sb[$];
  int sb_w[$];
  logic [6:0] last_bin;

  always #5 clk = ~clk;

  bcd_to_binary #(.DIGITS(2), .BIN_WIDTH(7)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_BCD(bcd),
    .o_Binary(bin), .o_Done(done), .o_Busy(busy), .o_Error(err)
  );

  bcd_to_binary #(.DIGITS(3), .BIN_WIDTH(10)) dut_w (
    .i_Clk(clk), .i_Rst(rst), .i_Start(w_start), .i_BCD(w_bcd),
    .o_Binary(w_bin), .o_Done(w_done), .o_Busy(w_busy), .o_Error(w_err)
  );

  // Accepted at edge N, o_Done is first seen on the negedge after edge N+BIN_WIDTH+1,
  // i.e. negedge number BIN_WIDTH+2 counting the one right after the accepting edge as 1.
  task automatic convert(input logic [7:0] v, input int expv, input bit check_val,
                         input logic exp_err);
    int cycles;
    int got;
    start = 1'b1;
    bcd   = v;
    if (check_val) sb.push_back(expv);
    @(negedge clk);
    start  = 1'b0;
    bcd    = 8'hxx;
    cycles = 1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear bcd=%h got=%b want=0", v, err);
    end
    while (done !== 1'b1 && cycles < 30) begin
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy bcd=%h cycle=%0d got=%b want=1", v, cycles, busy);
      end
      vectors++;
      if (bin !== last_bin) begin
        miscompares++;
        $display("FAIL hold bcd=%h cycle=%0d got=%0d want=%0d", v, cycles, bin, last_bin);
      end
      @(negedge clk);
      cycles++;
    end
    vectors++;
    if (cycles != 9) begin
      miscompares++;
      $display("FAIL latency bcd=%h got=%0d want=9", v, cycles);
      if (cycles >= 30) return;
    end
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("FAIL error bcd=%h got=%b want=%b", v, err, exp_err);
    end
    if (check_val) begin
      got = sb.pop_front();
      vectors++;
      if (bin !== 7'(got)) begin
        miscompares++;
        $display("FAIL value bcd=%h got=%0d want=%0d", v, bin, got);
      end
      last_bin = 7'(got);
    end else begin
      last_bin = bin;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bcd = 8'h00;
    w_start = 1'b0; w_bcd = 12'h000;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bin, done, busy, err} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_state got bin=%0d done=%b busy=%b err=%b want all 0", bin, done, busy, err);
    end
    vectors++;
    if ({w_bin, w_done, w_busy, w_err} !== 13'b0) begin
      miscompares++;
      $display("FAIL reset_state_wide got bin=%0d done=%b busy=%b want all 0", w_bin, w_done, w_busy);
    end
    rst = 1'b0;
    last_bin = 7'd0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    convert(8'h99, 99, 1'b1, 1'b0);
    vectors++;
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
    convert(8'h00, 0, 1'b1, 1'b0);
    convert(8'h47, 47, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 100; i++)
      convert({4'(i / 10), 4'(i % 10)}, i, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_held_start();
    int cycles;
    int got;
    start = 1'b1;
    bcd   = 8'h25;
    sb.push_back(25);
    @(negedge clk);
    bcd    = 8'h63;
    cycles = 1;
    while (done !== 1'b1 && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    vectors++;
    if (cycles != 9) begin
      miscompares++;
      $display("FAIL held_first_latency got=%0d want=9", cycles);
    end
    got = sb.pop_front();
    vectors++;
    if (bin !== 7'(got)) begin
      miscompares++;
      $display("FAIL held_first_value got=%0d want=%0d", bin, got);
    end
    sb.push_back(63);
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL held_accept got busy=%b want=1", busy);
    end
    while (done !== 1'b1 && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    vectors++;
    if (cycles != 9) begin
      miscompares++;
      $display("FAIL held_second_latency got=%0d want=9", cycles);
    end
    got = sb.pop_front();
    vectors++;
    if (bin !== 7'(got)) begin
      miscompares++;
      $display("FAIL held_second_value got=%0d want=%0d", bin, got);
    end
    last_bin = 7'(got);
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int pulses;
    start = 1'b1;
    bcd   = 8'h88;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({bin, done, busy, err} !== 10'b0) begin
      miscompares++;
      $display("FAIL abort_state got bin=%0d done=%b busy=%b err=%b want all 0", bin, done, busy, err);
    end
    last_bin = 7'd0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL abort_quiet got active_cycles=%0d want=0", pulses);
    end
    convert(8'h12, 12, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_check();
`ifdef BCD_TO_BINARY_CHECK_EN
    convert(8'h3A, 0, 1'b1, 1'b1);
    convert(8'h30, 30, 1'b1, 1'b0);
`else
    convert(8'h3A, 0, 1'b0, 1'b0);
    convert(8'h30, 30, 1'b1, 1'b0);
`endif
    @(negedge clk);
  endtask

  task automatic test_wide();
    logic [11:0] vals [3] = '{12'h999, 12'h000, 12'h507};
    int          exps [3] = '{999, 0, 507};
    int cycles;
    int got;
    for (int k = 0; k < 3; k++) begin
      w_start = 1'b1;
      w_bcd   = vals[k];
      sb_w.push_back(exps[k]);
      @(negedge clk);
      w_start = 1'b0;
      cycles  = 1;
      while (w_done !== 1'b1 && cycles < 40) begin
        @(negedge clk);
        cycles++;
      end
      vectors++;
      if (cycles != 12) begin
        miscompares++;
        $display("FAIL wide_latency bcd=%h got=%0d want=12", vals[k], cycles);
      end
      got = sb_w.pop_front();
      vectors++;
      if (w_bin !== 10'(got)) begin
        miscompares++;
        $display("FAIL wide_value bcd=%h got=%0d want=%0d", vals[k], w_bin, got);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_held_start();
    test_reset_abort();
    test_check();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
